// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: word memory with a program-load port feeding a 2-entry response FIFO.
// Build option IFETCH_RANGE_CHECK_EN: flag out-of-range fetches with rsp_err instead of wrapping.
module instr_fetch_responder #(
  parameter int W     = 32,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         req_valid,
  input  logic [W-1:0] req_addr,
  output logic         req_ready,
  input  logic         flush,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_data,
  output logic [W-1:0] rsp_addr,
  output logic         rsp_err,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [31:0]  wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [31:0]  r_mem [DEPTH];
  logic [1:0]   r_state;
  logic [31:0]  r_d0, r_d1;
  logic [W-1:0] r_a0, r_a1;
  logic         r_e0, r_e1;

  logic          w_push, w_pop, w_new_e;
  logic [AW-1:0] w_rd_idx, w_wr_idx;
  logic [31:0]   w_new_d;

  assign w_rd_idx = req_addr[AW-1:0];
  assign w_wr_idx = AW'(wr_addr % W'(DEPTH));

`ifdef IFETCH_RANGE_CHECK_EN
  assign w_new_e = ({1'b0, req_addr} >= (W+1)'(DEPTH));
`else
  assign w_new_e = 1'b0;
`endif

  // Array read happens before this edge's write lands, so a colliding write returns old data.
  assign w_new_d = w_new_e ? 32'd0 : r_mem[w_rd_idx];

  assign req_ready = clr_n && !flush && (r_state != S_FULL || rsp_ready);
  assign rsp_valid = (r_state != S_EMPTY);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready && !flush;

  assign rsp_data = rsp_valid ? r_d0 : 32'd0;
  assign rsp_addr = rsp_valid ? r_a0 : '0;
  assign rsp_err  = rsp_valid ? r_e0 : 1'b0;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[w_wr_idx] <= wr_data;
  end

  // Slot 0 is always the head presented on the response outputs.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= S_EMPTY;
      r_d0 <= '0; r_a0 <= '0; r_e0 <= 1'b0;
      r_d1 <= '0; r_a1 <= '0; r_e1 <= 1'b0;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_d0 <= w_new_d; r_a0 <= req_addr; r_e0 <= w_new_e;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_d1 <= w_new_d; r_a1 <= req_addr; r_e1 <= w_new_e;
              r_state <= S_FULL;
            end
            2'b01: r_state <= S_EMPTY;
            2'b11: begin
              r_d0 <= w_new_d; r_a0 <= req_addr; r_e0 <= w_new_e;
            end
            default: ;
          endcase
        end
        S_FULL: begin
          if (w_pop) begin
            r_d0 <= r_d1; r_a0 <= r_a1; r_e0 <= r_e1;
            if (w_push) begin
              r_d1 <= w_new_d; r_a1 <= req_addr; r_e1 <= w_new_e;
            end else begin
              r_state <= S_ONE;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_responder.md
INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL have parameter W, default 32: width of request/response address.
REQ-002 SHALL have parameter DEPTH, default 256: instruction words stored; power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port clr_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  fetch address offered by program counter.
REQ-006 SHALL have port req_addr  input  W  word address; consecutive instructions differ by 1.
REQ-007 SHALL have port req_ready  output  1  responder accepts request this cycle.
REQ-008 SHALL have port flush  input  1  branch redirect; discard all pending responses.
REQ-009 SHALL have port rsp_valid  output  1  instruction word available.
REQ-010 SHALL have port rsp_ready  input  1  decoder consumes response this cycle.
REQ-011 SHALL have port rsp_data  output  32  instruction word.
REQ-012 SHALL have port rsp_addr  output  W  address that produced rsp_data.
REQ-013 SHALL have port rsp_err  output  1  address out of range (see Configuration).
REQ-014 SHALL have ports wr_en  input  1, wr_addr  input  W, wr_data  input  32: program-load write port.

Function
REQ-015 Request SHALL be accepted at a posedge where req_valid && req_ready.
REQ-016 Accepted request SHALL read memory synchronously and push {data, addr, err} into a 2-entry response FIFO at that same edge; rsp_valid rises next cycle (latency 1).
REQ-017 Response SHALL pop at a posedge where rsp_valid && rsp_ready; FIFO order = acceptance order.
REQ-018 FIFO occupancy states SHALL be EMPTY, ONE, FULL; push-only advances one state, pop-only retreats one, push+pop holds.
REQ-019 req_ready SHALL equal !flush && (state != FULL || rsp_ready), combinational.
REQ-020 rsp_valid SHALL equal state != EMPTY; rsp_data/rsp_addr/rsp_err SHALL be 0 when EMPTY.
REQ-021 Response outputs SHALL remain stable while rsp_valid && !rsp_ready.
REQ-022 flush high at a posedge SHALL force state EMPTY; no push, no pop that cycle.
REQ-023 wr_en at a posedge SHALL write wr_data to mem[wr_addr mod DEPTH]; writes ignore clr_n, flush and FIFO state.
REQ-024 Read and write to same word at same edge SHALL return old data.
REQ-025 Address index SHALL be req_addr[log2(DEPTH)-1:0].

Reset
REQ-026 clr_n low at a posedge SHALL set state EMPTY; rsp_valid, rsp_data, rsp_addr, rsp_err = 0.
REQ-027 While clr_n low, req_ready SHALL be 0; in-flight and queued responses are dropped.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro IFETCH_RANGE_CHECK_EN defined: rsp_err = 1 when req_addr >= DEPTH, rsp_data = 0 for that response; still queued in order.
REQ-030 Macro IFETCH_RANGE_CHECK_EN undefined: address wraps mod DEPTH, rsp_err tied 0.

Verification
REQ-031 Load mem[0..3]=0xA0..0xA3; req 0,1,2,3 back-to-back, rsp_ready=1 -> responses 0xA0..0xA3, addr 0..3, each 1 cycle after acceptance, req_ready constantly 1.
REQ-032 rsp_ready=0, requests 0,1,2 -> two accepted, req_ready=0 on third, outputs hold 0xA0; raise rsp_ready -> 0xA0, 0xA1, then addr 2 accepted.
REQ-033 FULL, flush=1 for one cycle with req_valid=1 -> rsp_valid=0 next cycle, no request accepted; next req 3 -> 0xA3.
REQ-034 wr_en to addr 5 with value 0xBEEF and simultaneous req 5 -> old value returned; repeat req 5 -> 0xBEEF.
REQ-035 Macro defined, DEPTH=256, req 300 -> rsp_err=1, rsp_data=0; macro undefined -> returns mem[44], rsp_err=0.
REQ-036 clr_n low one cycle while FULL -> rsp_valid=0 and all outputs 0 next cycle; memory still reads 0xA0 at addr 0.
